// File: rtl/log_drain_pkg.sv
// Shared types and constants for the BRAM log drain engine.
package log_drain_pkg;

    localparam int unsigned WORD_BITW  = 32;
    localparam int unsigned ENTRY_BITW = 3 * WORD_BITW;

    // Word offsets within one 4-word logger entry; word 3 is unused.
    localparam logic [1:0] WORD_LEN_ID = 2'd0;
    localparam logic [1:0] WORD_ADDR   = 2'd1;
    localparam logic [1:0] WORD_TS     = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_RD2,
        ST_CAP,
        ST_EMIT,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [31:0] ts;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [7:0]  id;
        logic [15:0] pad;
    } log_entry_t;

endpackage

// File: rtl/axi_bram_log_drain.sv
// Drains N logged entries from the logger BRAM port and streams them out as
// 96-bit records with Last. Optional macro LOG_DRAIN_CLEAR_EN adds a logger
// clear pulse alongside Done after a completed non-empty drain.
module axi_bram_log_drain
    import log_drain_pkg::*;
#(
    parameter  int unsigned NUM_SER_BRAMS  = 12,
    parameter  int unsigned BRAM_ADDR_BITW = 32,
    localparam int unsigned MAX_ENT        = 1024 * NUM_SER_BRAMS,
    localparam int unsigned CNT_BITW       = $clog2(MAX_ENT) + 1
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RI,
    input  logic                      Start_SI,
    input  logic                      Abort_SI,
    input  logic [CNT_BITW-1:0]       NumEntries_DI,
    output logic                      Busy_SO,
    output logic                      Done_SO,
    output logic                      BramEn_SO,
    output logic [BRAM_ADDR_BITW-1:0] BramAddr_SO,
    input  logic [WORD_BITW-1:0]      BramRd_DI,
    output logic                      Valid_SO,
    input  logic                      Ready_SI,
    output logic [ENTRY_BITW-1:0]     Entry_DO,
    output logic                      Last_SO,
    output logic                      LogClear_SO
);

    state_t                    state_q, state_d;
    logic [CNT_BITW-1:0]       cnt_q, cnt_d;
    logic [CNT_BITW-1:0]       idx_q, idx_d;
    logic [WORD_BITW-1:0]      word0_q, word0_d;
    logic [WORD_BITW-1:0]      word1_q, word1_d;
    logic [WORD_BITW-1:0]      word2_q, word2_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      bram_en_q, bram_en_d;
    logic [BRAM_ADDR_BITW-1:0] bram_addr_q, bram_addr_d;
    logic                      valid_q, valid_d;
    logic                      last_q, last_d;
    logic [1:0]                word_sel;
    log_entry_t                entry_c;

    // Next-state, datapath and next-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        word0_d     = word0_q;
        word1_d     = word1_q;
        word2_d     = word2_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        bram_en_d   = 1'b0;
        bram_addr_d = '0;
        valid_d     = 1'b0;
        last_d      = 1'b0;
        word_sel    = WORD_LEN_ID;

        case (state_q)
            ST_IDLE: begin
                if (Start_SI && !Abort_SI) begin
                    cnt_d   = (NumEntries_DI > CNT_BITW'(MAX_ENT)) ? CNT_BITW'(MAX_ENT)
                                                                   : NumEntries_DI;
                    idx_d   = '0;
                    state_d = (cnt_d == '0) ? ST_DONE : ST_RD0;
                end
            end
            ST_RD0: state_d = ST_RD1;
            ST_RD1: begin
                word0_d = BramRd_DI;
                state_d = ST_RD2;
            end
            ST_RD2: begin
                word1_d = BramRd_DI;
                state_d = ST_CAP;
            end
            ST_CAP: begin
                word2_d = BramRd_DI;
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (Ready_SI) begin
                    idx_d   = idx_q + CNT_BITW'(1);
                    state_d = last_q ? ST_DONE : ST_RD0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides the next state from any busy state.
        if (Abort_SI && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end

        case (state_d)
            ST_RD0: begin bram_en_d = 1'b1; word_sel = WORD_LEN_ID; end
            ST_RD1: begin bram_en_d = 1'b1; word_sel = WORD_ADDR;   end
            ST_RD2: begin bram_en_d = 1'b1; word_sel = WORD_TS;     end
            default: ;
        endcase

        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        valid_d = (state_d == ST_EMIT);
        last_d  = valid_d && (idx_d == cnt_d - CNT_BITW'(1));
        if (bram_en_d) begin
            bram_addr_d = BRAM_ADDR_BITW'({idx_d, word_sel, 2'b00});
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            word0_q     <= '0;
            word1_q     <= '0;
            word2_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            valid_q     <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            word0_q     <= word0_d;
            word1_q     <= word1_d;
            word2_q     <= word2_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bram_en_q   <= bram_en_d;
            bram_addr_q <= bram_addr_d;
            valid_q     <= valid_d;
            last_q      <= last_d;
        end
    end

`ifdef LOG_DRAIN_CLEAR_EN
    logic clear_q;

    // Clear pulse accompanies Done only when entries were actually drained.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            clear_q <= 1'b0;
        end else begin
            clear_q <= (state_d == ST_DONE) && (cnt_d != '0);
        end
    end

    assign LogClear_SO = clear_q;
`else
    assign LogClear_SO = 1'b0;
`endif

    assign entry_c     = {word2_q, word1_q, word0_q};
    assign Entry_DO    = entry_c;
    assign Busy_SO     = busy_q;
    assign Done_SO     = done_q;
    assign BramEn_SO   = bram_en_q;
    assign BramAddr_SO = bram_addr_q;
    assign Valid_SO    = valid_q;
    assign Last_SO     = last_q;

endmodule

// File: tb/tb_axi_bram_log_drain.sv
// Randomized self-checking bench for axi_bram_log_drain against a
// per-entry reference model of the drain address/record sequence.
module tb_axi_bram_log_drain;

    localparam int unsigned MAX_ENT  = 12288;
    localparam int unsigned CNT_BITW = 15;

    logic                clk;
    logic                rst;
    logic                start;
    logic                abort;
    logic [CNT_BITW-1:0] num;
    logic                busy;
    logic                done;
    logic                en;
    logic [31:0]         addr;
    logic [31:0]         rd;
    logic                valid;
    logic                ready;
    logic [95:0]         entry;
    logic                last;
    logic                clear;

    int   checks = 0;
    int   errors = 0;
    logic fixed_pat = 1'b0;
    logic [31:0] seed = 32'h1234_5678;

    axi_bram_log_drain #(
        .NUM_SER_BRAMS  (12),
        .BRAM_ADDR_BITW (32)
    ) dut (
        .Clk_CI        (clk),
        .Rst_RI        (rst),
        .Start_SI      (start),
        .Abort_SI      (abort),
        .NumEntries_DI (num),
        .Busy_SO       (busy),
        .Done_SO       (done),
        .BramEn_SO     (en),
        .BramAddr_SO   (addr),
        .BramRd_DI     (rd),
        .Valid_SO      (valid),
        .Ready_SI      (ready),
        .Entry_DO      (entry),
        .Last_SO       (last),
        .LogClear_SO   (clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Content of the logger BRAM at a byte address.
    function automatic logic [31:0] bram_word(input logic [31:0] a);
        if (fixed_pat) begin
            case (a[3:2])
                2'd0:    return 32'h0000_0A05;
                2'd1:    return 32'h4000_1000;
                2'd2:    return 32'h0000_00FF;
                default: return 32'hDEAD_BEEF;
            endcase
        end
        return (a * 32'h9E37_79B1) ^ seed;
    endfunction

    // One-cycle-latency BRAM read port.
    always @(posedge clk) begin
        if (en) rd <= bram_word(addr);
    end

    // n-th read of a drain: entry n/3, word n%3, 4 words per entry, 4 bytes per word.
    function automatic logic [31:0] exp_addr(input int n);
        return 32'(((n / 3) * 4 + (n % 3)) * 4);
    endfunction

    function automatic logic [95:0] exp_rec(input int k);
        return {bram_word(32'(k * 16 + 8)), bram_word(32'(k * 16 + 4)), bram_word(32'(k * 16))};
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"},  128'(busy),  128'(0));
        chk({tag, "_done"},  128'(done),  128'(0));
        chk({tag, "_en"},    128'(en),    128'(0));
        chk({tag, "_valid"}, 128'(valid), 128'(0));
        chk({tag, "_clear"}, 128'(clear), 128'(0));
    endtask

    // Runs one drain of n_req entries; ready asserted with rdy_pct percent
    // probability per cycle; abort_rd >= 0 aborts on that read index.
    task automatic run_drain(input int n_req, input int rdy_pct, input int abort_rd);
        int cnt, reads, recs, budget;
        bit finished, aborted;
        logic exp_clear;
        cnt      = (n_req > int'(MAX_ENT)) ? int'(MAX_ENT) : n_req;
        reads    = 0;
        recs     = 0;
        finished = 1'b0;
        aborted  = 1'b0;
        budget   = cnt * 5 * 40 + 20;
        @(negedge clk);
        start = 1'b1;
        num   = CNT_BITW'(n_req);
        @(posedge clk);
        #1 start = 1'b0;
        num = CNT_BITW'($urandom_range(MAX_ENT));
        for (int cyc = 0; cyc < budget && !finished && !aborted; cyc++) begin
            @(negedge clk);
            ready = ($urandom_range(99) < 32'(rdy_pct));
            chk("busy", 128'(busy), 128'(1));
            chk("en_excl_valid", 128'(en & valid), 128'(0));
            if (en) begin
                chk("rd_in_range", 128'(reads < 3 * cnt), 128'(1));
                chk("rd_addr", 128'(addr), 128'(exp_addr(reads)));
                if (reads == abort_rd) begin
                    abort   = 1'b1;
                    aborted = 1'b1;
                end
                reads++;
            end
            if (valid) begin
                chk("entry", 128'(entry), 128'(exp_rec(recs)));
                chk("last", 128'(last), 128'(recs == cnt - 1));
                if (rdy_pct == 100) chk("rec_cycle", 128'(cyc), 128'(4 + 5 * recs));
                if (ready) recs++;
            end
            if (done) begin
                finished = 1'b1;
                start    = 1'b0;
`ifdef LOG_DRAIN_CLEAR_EN
                exp_clear = (cnt > 0);
`else
                exp_clear = 1'b0;
`endif
                chk("rec_count", 128'(recs), 128'(cnt));
                chk("rd_count", 128'(reads), 128'(3 * cnt));
                chk("clear_with_done", 128'(clear), 128'(exp_clear));
                if (rdy_pct == 100) chk("done_cycle", 128'(cyc), 128'(5 * cnt));
            end else begin
                start = aborted ? 1'b0 : ($urandom_range(3) == 0);
            end
        end
        if (aborted) begin
            @(negedge clk);
            abort = 1'b0;
            chk_quiet("abort");
            repeat (6) begin
                @(negedge clk);
                chk("abort_no_done", 128'(done | clear), 128'(0));
            end
        end else if (finished) begin
            @(negedge clk);
            chk("done_pulse", 128'(done), 128'(0));
            chk("idle_after", 128'(busy), 128'(0));
        end else begin
            chk("timeout", 128'(0), 128'(1));
            start = 1'b0;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        ready = 1'b0;
        num   = '0;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        chk("reset_entry", 128'(entry), 128'(0));
        chk("reset_addr", 128'(addr), 128'(0));
        chk("reset_last", 128'(last), 128'(0));
        rst = 1'b0;

        // Basic 3-entry drain with Ready held high.
        run_drain(3, 100, -1);

        // Fixed BRAM pattern gives a known record.
        fixed_pat = 1'b1;
        run_drain(2, 100, -1);
        chk("fixed_entry", 128'(entry), 128'(96'h0000_00FF_4000_1000_0000_0A05));
        fixed_pat = 1'b0;

        // Empty drain.
        run_drain(0, 100, -1);

        // Random lengths, random back-pressure, random BRAM content.
        for (int t = 0; t < 8; t++) begin
            seed = $urandom;
            run_drain(int'($urandom_range(1, 8)), int'($urandom_range(20, 100)), -1);
        end

        // Abort on the second read of entry 2, then restart from entry 0.
        run_drain(5, 100, 7);
        run_drain(3, 100, -1);

        // Start and Abort together in IDLE: stays idle.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        num   = CNT_BITW'(4);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk_quiet("start_abort");

        // Asynchronous reset in the middle of a drain.
        start = 1'b1;
        num   = CNT_BITW'(4);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk_quiet("async_rst");
        chk("async_rst_entry", 128'(entry), 128'(0));
        chk("async_rst_addr", 128'(addr), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        run_drain(2, 60, -1);

        // Oversized request clamps to the logger capacity.
        seed = $urandom;
        run_drain(20000, 100, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
